// File: rtl/alu_pkg.sv
// alu_pkg: operation codes shared by the ALU and the CPU control decode.
package alu_pkg;

   localparam int ALU_MODE_W = 5;

   typedef enum logic [ALU_MODE_W-1:0] {
      ALU_ADD = 5'd0,
      ALU_AND = 5'd1,
      ALU_OR  = 5'd2,
      ALU_EOR = 5'd3,
      ALU_SR  = 5'd4,
      ALU_SUB = 5'd5
   } alu_mode_t;

   // True for the two carry-chain operations that may run in decimal mode.
   function automatic logic alu_is_arith(input logic [ALU_MODE_W-1:0] m);
      return (m == ALU_ADD) || (m == ALU_SUB);
   endfunction

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/control bundle from the datapath into the ALU and the
// registered result/flags coming back out.
interface alu_if #(parameter int WIDTH = 8);
   import alu_pkg::*;

   logic                  en;
   logic [ALU_MODE_W-1:0] mode;
   logic [WIDTH-1:0]      alu_a;
   logic [WIDTH-1:0]      alu_b;
   logic                  carry_in;
   logic                  decimal_mode;

   logic [WIDTH-1:0]      alu_out;
   logic                  carry_out;
   logic                  overflow;
   logic                  zero;
   logic                  sign;

   modport master (
      output en, mode, alu_a, alu_b, carry_in, decimal_mode,
      input  alu_out, carry_out, overflow, zero, sign
   );

   modport slave (
      input  en, mode, alu_a, alu_b, carry_in, decimal_mode,
      output alu_out, carry_out, overflow, zero, sign
   );

endinterface

// File: rtl/alu_bcd_adjust.sv
// alu_bcd_adjust: combinational packed-BCD add/subtract. Each nibble is
// summed with the carry from the nibble below and corrected by 6 when it
// leaves the 0-9 range, so the carry ripples in decimal, not binary.
module alu_bcd_adjust #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             sub,
   output logic [WIDTH-1:0] result,
   output logic             carry_out
);

   logic [4:0] dig;
   logic       c;

   // Ripple through the nibbles; for subtract, carry means "no borrow".
   always_comb begin
      dig    = '0;
      c      = carry_in;
      result = '0;
      for (int i = 0; i < WIDTH / 4; i++) begin
         if (!sub) begin
            dig = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            if (dig > 5'd9) begin
               dig = dig + 5'd6;
               c   = 1'b1;
            end else begin
               c   = 1'b0;
            end
         end else begin
            dig = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, ~c};
            if (dig[4]) begin
               dig = dig - 5'd6;
               c   = 1'b0;
            end else begin
               c   = 1'b1;
            end
         end
         result[4*i +: 4] = dig[3:0];
      end
      carry_out = c;
   end

endmodule

// File: rtl/alu.sv
// alu: 6502-style ALU (ADC/AND/ORA/EOR/LSR-ROR/SBC) with registered result
// and C/V/Z/N flags, one cycle of latency.
// Define ALU_DECIMAL_EN to honour decimal_mode for ADD/SUB (BCD); without
// it decimal_mode is accepted but ignored.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic   clk,
   input logic   reset,
   alu_if.slave  bus
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH:0]   sum_add;
   logic [WIDTH:0]   sum_sub;
   logic [WIDTH-1:0] res_c;
   logic             c_c;
   logic             v_c;

`ifdef ALU_DECIMAL_EN
   logic [WIDTH-1:0] bcd_res;
   logic             bcd_c;

   alu_bcd_adjust #(.WIDTH(WIDTH)) u_bcd (
      .a         (bus.alu_a),
      .b         (bus.alu_b),
      .carry_in  (bus.carry_in),
      .sub       (bus.mode == ALU_SUB),
      .result    (bcd_res),
      .carry_out (bcd_c)
   );
`else
   logic unused_decimal_mode;
   assign unused_decimal_mode = bus.decimal_mode;
`endif

   assign sum_add = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}  + {{WIDTH{1'b0}}, bus.carry_in};
   assign sum_sub = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {{WIDTH{1'b0}}, bus.carry_in};

   // Next result and C/V; undefined codes pass A through with carry intact.
   always_comb begin
      res_c = bus.alu_a;
      c_c   = bus.carry_in;
      v_c   = 1'b0;
      case (bus.mode)
         ALU_ADD: begin
            res_c = sum_add[MSB:0];
            c_c   = sum_add[WIDTH];
            v_c   = (bus.alu_a[MSB] == bus.alu_b[MSB]) && (sum_add[MSB] != bus.alu_a[MSB]);
         end
         ALU_SUB: begin
            res_c = sum_sub[MSB:0];
            c_c   = sum_sub[WIDTH];
            v_c   = (bus.alu_a[MSB] != bus.alu_b[MSB]) && (sum_sub[MSB] != bus.alu_a[MSB]);
         end
         ALU_AND: res_c = bus.alu_a & bus.alu_b;
         ALU_OR:  res_c = bus.alu_a | bus.alu_b;
         ALU_EOR: res_c = bus.alu_a ^ bus.alu_b;
         ALU_SR: begin
            res_c = {bus.carry_in, bus.alu_a[MSB:1]};
            c_c   = bus.alu_a[0];
         end
         default: ;
      endcase
`ifdef ALU_DECIMAL_EN
      // V stays from the binary result; only the value and carry are decimal.
      if (bus.decimal_mode && alu_is_arith(bus.mode)) begin
         res_c = bcd_res;
         c_c   = bcd_c;
      end
`endif
   end

   // Output registers; Z and N always follow the value actually stored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.alu_out   <= '0;
         bus.carry_out <= 1'b0;
         bus.overflow  <= 1'b0;
         bus.zero      <= 1'b0;
         bus.sign      <= 1'b0;
      end else if (bus.en) begin
         bus.alu_out   <= res_c;
         bus.carry_out <= c_c;
         bus.overflow  <= v_c;
         bus.zero      <= (res_c == '0);
         bus.sign      <= res_c[MSB];
      end
   end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors for alu with hand-computed results and flags.
module tb_alu;
   import alu_pkg::*;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;

   alu_if #(.WIDTH(8)) bus ();

   alu #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag, input logic [7:0] o, input logic c,
                          input logic v, input logic z, input logic n);
      chk({tag, ".out"}, {24'd0, bus.alu_out}, {24'd0, o});
      chk({tag, ".c"},   {31'd0, bus.carry_out}, {31'd0, c});
      chk({tag, ".v"},   {31'd0, bus.overflow},  {31'd0, v});
      chk({tag, ".z"},   {31'd0, bus.zero},      {31'd0, z});
      chk({tag, ".n"},   {31'd0, bus.sign},      {31'd0, n});
   endtask

   task automatic drive(input logic [4:0] m, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic dm);
      bus.en           = 1'b1;
      bus.mode         = m;
      bus.alu_a        = a;
      bus.alu_b        = b;
      bus.carry_in     = cin;
      bus.decimal_mode = dm;
   endtask

   // Apply one operation, clock it in, check the registered result.
   task automatic run_op(input string tag, input logic [4:0] m, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic dm,
                         input logic [7:0] o, input logic c, input logic v,
                         input logic z, input logic n);
      @(negedge clk);
      drive(m, a, b, cin, dm);
      @(posedge clk);
      #1;
      chk_all(tag, o, c, v, z, n);
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      reset  = 1'b0;
      drive(ALU_OR, 8'hF0, 8'h0F, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      //      tag         mode     a      b      cin   dm    out    C     V     Z     N
      run_op("add_v",    ALU_ADD, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1);
      run_op("add_wrap", ALU_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      run_op("add_7f",   ALU_ADD, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
      run_op("sub_v",    ALU_SUB, 8'h50, 8'hB0, 1'b1, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1);
      run_op("sub_eq",   ALU_SUB, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      run_op("sub_brw",  ALU_SUB, 8'h05, 8'h05, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op("and",      ALU_AND, 8'hF0, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      run_op("or",       ALU_OR,  8'hF0, 8'h0F, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op("eor",      ALU_EOR, 8'hFF, 8'h0F, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
      run_op("lsr",      ALU_SR,  8'h01, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      run_op("ror",      ALU_SR,  8'h80, 8'h00, 1'b1, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op("undef7",   5'd7,    8'h3C, 8'hFF, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op("undef31",  5'd31,   8'h00, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef ALU_DECIMAL_EN
      run_op("dec_add",  ALU_ADD, 8'h58, 8'h46, 1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0);
`else
      run_op("dec_add",  ALU_ADD, 8'h58, 8'h46, 1'b1, 1'b1, 8'h9F, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
      run_op("dec_sub",  ALU_SUB, 8'h46, 8'h12, 1'b1, 1'b1, 8'h34, 1'b1, 1'b0, 1'b0, 1'b0);

      // Hold: en low keeps 0x80/V from add_7f-style result despite new operands.
      run_op("pre_hold", ALU_ADD, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(ALU_SUB, 8'h11 * i[7:0], 8'h33, 1'b1, 1'b0);
         bus.en = 1'b0;
         @(posedge clk);
         #1;
         chk_all("hold", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
      end

      // Asynchronous reset mid-stream, overriding en.
      run_op("pre_rst", ALU_OR, 8'hF0, 8'h0F, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk_all("rst_async", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk_all("rst_hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      run_op("post_rst", ALU_EOR, 8'hA5, 8'h0F, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 8-bit 6502-style arithmetic/logic unit inside the CPU datapath; operands are the accumulator and the data bus.
- Performs ADD (ADC), AND, OR, EOR, shift-right (LSR/ROR) and SUB (SBC) selected by a 5-bit mode code.
- Produces the result plus carry, overflow, zero and sign flags for the processor status register.
- Result and flags are registered: one cycle of latency.

Parameters:
- WIDTH, 8, datapath width in bits; must be a multiple of 4; all flag rules refer to the MSB as bit WIDTH-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  capture enable; when 1, operands are sampled and outputs update at the next edge.
- mode  input  5  operation select: 0 ADD, 1 AND, 2 OR, 3 EOR, 4 SR, 5 SUB.
- alu_a  input  WIDTH  operand A (accumulator); the only operand for SR.
- alu_b  input  WIDTH  operand B (memory/data-bus value).
- carry_in  input  1  carry in; for SUB, 1 means no borrow.
- decimal_mode  input  1  BCD request for ADD/SUB; used only with DECIMAL_EN.
- alu_out  output  WIDTH  registered result.
- carry_out  output  1  registered carry.
- overflow  output  1  registered signed overflow (V).
- zero  output  1  registered, 1 when alu_out is 0.
- sign  output  1  registered copy of alu_out MSB.

Behaviour:
- Reset low forces all outputs to 0 immediately. The values hold while reset stays low; reset overrides en.
- en=1: outputs update on the next rising edge from operands sampled at that edge. en=0: all outputs hold their previous values.
- There is no handshake; back-to-back operations are allowed every cycle.
- ADD: r = a + b + carry_in (WIDTH+1 bits); carry_out = r[WIDTH]; overflow = (a[MSB]==b[MSB]) & (r[MSB]!=a[MSB]).
- SUB: r = a + ~b + carry_in; carry_out = 1 if no borrow; overflow = (a[MSB]!=b[MSB]) & (r[MSB]!=a[MSB]).
- AND, OR, EOR: out = a op b; carry_out = carry_in; overflow = 0.
- SR: out = {carry_in, a[MSB:1]}; carry_out = a[0]; overflow = 0. For a plain LSR the CPU drives carry_in = 0.
- Undefined mode codes (6–31): out = a; carry_out = carry_in; overflow = 0.
- zero and sign are always derived from the final alu_out value.
- All arithmetic wraps modulo 2^WIDTH. No internal state exists besides the output registers.

Optional Feature:
- ALU_DECIMAL_EN defined, decimal_mode=1, ADD: BCD add with per-nibble adjust (+6 where a nibble exceeds 9 or carries); carry_out is the decimal carry.
- ALU_DECIMAL_EN defined, decimal_mode=1, SUB: BCD subtract with per-nibble adjust (-6 where a nibble borrows); carry_out = no decimal borrow.
- In both decimal cases, overflow is computed from the binary result, and zero/sign from the adjusted result.
- ALU_DECIMAL_EN undefined: decimal_mode is ignored and all arithmetic is binary. The port remains present.

Decomposition:
- Package alu_pkg holds the 5-bit mode constants ALU_ADD=0, ALU_AND=1, ALU_OR=2, ALU_EOR=3, ALU_SR=4, ALU_SUB=5, as a typedef enum alu_mode_t. The CPU control decode shares this package.
- One sub-module, alu_bcd_adjust: combinational per-nibble decimal correction, instantiated only under ALU_DECIMAL_EN.

Test Plan:
- ADD a=0x50, b=0x50, cin=0 → next cycle out=0xA0, C=0, V=1, N=1, Z=0. ADD a=0xFF, b=0x01, cin=0 → 0x00, C=1, Z=1, V=0.
- SUB a=0x50, b=0xB0, cin=1 → 0xA0, C=0, V=1, N=1. SUB a=0x05, b=0x05, cin=1 → 0x00, C=1, Z=1.
- AND 0xF0/0x0F → 0x00, Z=1, C=cin. OR 0xF0/0x0F → 0xFF, N=1. EOR 0xFF/0x0F → 0xF0, N=1, V=0.
- SR a=0x01, cin=0 → 0x00, C=1, Z=1. SR a=0x80, cin=1 → 0xC0, C=0, N=1.
- Control: en=0 holds the prior outputs for 3 cycles despite operand changes. Reset low mid-stream → outputs 0 before the next edge and stay 0 until release.
- ALU_DECIMAL_EN with decimal_mode=1: ADD 0x58+0x46, cin=1 → 0x05, C=1. SUB 0x46−0x12, cin=1 → 0x34, C=1. Without the macro, the same ADD → 0x9F, C=0.
